// File: rtl/feedback_scorer_if.sv
// Guess/feedback bundle for feedback_scorer.
// Master offers guesses; slave returns scored feedback.
interface feedback_scorer_if #(
  parameter int PEGS    = 4,
  parameter int COLOR_W = 3
);
  localparam int CNT_W = $clog2(PEGS + 1);

  logic [PEGS*COLOR_W-1:0] guess;
  logic                    guess_valid;
  logic                    guess_ready;
  logic [2*PEGS-1:0]       fb;
  logic [CNT_W-1:0]        exact_cnt;
  logic [CNT_W-1:0]        partial_cnt;
  logic                    fb_valid;

  modport master (
    output guess, guess_valid,
    input  guess_ready, fb, exact_cnt,
    input  partial_cnt, fb_valid
  );

  modport slave (
    input  guess, guess_valid,
    output guess_ready, fb, exact_cnt,
    output partial_cnt, fb_valid
  );
endinterface

// File: rtl/feedback_scorer.sv
// Mastermind-style scorer: exact pass, then one
// partial-match peg per cycle, then a DONE pulse.
module feedback_scorer #(
  parameter int PEGS      = 4,
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 8,
  parameter int TURN_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    new_game,
  input  logic [PEGS*COLOR_W-1:0] code,
  feedback_scorer_if.slave        bus,
  output logic [TURN_W-1:0]       turn,
  output logic                    last_turn,
  output logic                    win,
  output logic                    game_over
);
  localparam int CNT_W = $clog2(PEGS + 1);
  localparam int IW    = $clog2(PEGS);
  localparam int GW    = PEGS * COLOR_W;

  typedef enum logic [1:0] {
    IDLE, EXACT, PARTIAL, DONE
  } state_t;

  state_t              state_q;
  logic [GW-1:0]       code_q;
  logic [GW-1:0]       guess_q;
  logic [2*PEGS-1:0]   wk_q;
  logic [PEGS-1:0]     used_q;
  logic [IW-1:0]       idx_q;
  logic [2*PEGS-1:0]   fb_q;
  logic [CNT_W-1:0]    ex_q;
  logic [CNT_W-1:0]    pa_q;
  logic                fbv_q;
  logic [TURN_W-1:0]   turn_q;
  logic                win_q;
  logic                over_q;

  logic [2*PEGS-1:0]   ex_wk_d;
  logic [PEGS-1:0]     ex_used_d;
  logic [2*PEGS-1:0]   pt_wk_d;
  logic [PEGS-1:0]     pt_used_d;
  logic [CNT_W-1:0]    ex_n_d;
  logic [CNT_W-1:0]    pa_n_d;
  logic [TURN_W-1:0]   turn_d;
  logic                rdy;

  assign rdy = (state_q == IDLE) && !over_q;

  // Exact pass: equal pegs score 2 and consume their code peg.
  always_comb begin
    ex_wk_d   = '0;
    ex_used_d = '0;
    for (int i = 0; i < PEGS; i++) begin
      if (guess_q[i*COLOR_W +: COLOR_W] ==
          code_q[i*COLOR_W +: COLOR_W]) begin
        ex_wk_d[2*i +: 2] = 2'd2;
        ex_used_d[i]      = 1'b1;
      end
    end
  end

  // Partial step for guess peg idx_q: lowest free code peg wins.
  always_comb begin
    int unsigned k;
    logic found;
    logic [COLOR_W-1:0] gp;
    k         = 32'(idx_q);
    found     = 1'b0;
    pt_wk_d   = wk_q;
    pt_used_d = used_q;
    gp        = guess_q[k*COLOR_W +: COLOR_W];
    if (wk_q[2*k +: 2] != 2'd2) begin
      for (int j = 0; j < PEGS; j++) begin
        if (!found && !used_q[j] &&
            code_q[j*COLOR_W +: COLOR_W] == gp) begin
          found        = 1'b1;
          pt_used_d[j] = 1'b1;
          pt_wk_d[2*k +: 2] = 2'd1;
        end
      end
    end
  end

  // Final counts taken from the last partial step's result.
  always_comb begin
    ex_n_d = '0;
    pa_n_d = '0;
    for (int i = 0; i < PEGS; i++) begin
      if (pt_wk_d[2*i +: 2] == 2'd2)
        ex_n_d = ex_n_d + CNT_W'(1);
      if (pt_wk_d[2*i +: 2] == 2'd1)
        pa_n_d = pa_n_d + CNT_W'(1);
    end
  end

  // Turn counter saturates at MAX_TURNS.
  always_comb begin
    turn_d = turn_q;
    if (turn_q != TURN_W'(MAX_TURNS))
      turn_d = turn_q + TURN_W'(1);
  end

  // Scoring FSM; reset beats new_game beats handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      guess_q <= '0;
      wk_q    <= '0;
      used_q  <= '0;
      idx_q   <= '0;
      fb_q    <= '0;
      ex_q    <= '0;
      pa_q    <= '0;
      fbv_q   <= 1'b0;
      turn_q  <= '0;
      win_q   <= 1'b0;
      over_q  <= 1'b0;
    end else if (new_game) begin
      state_q <= IDLE;
      code_q  <= code;
      fb_q    <= '0;
      ex_q    <= '0;
      pa_q    <= '0;
      fbv_q   <= 1'b0;
      turn_q  <= '0;
      win_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      fbv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.guess_valid && rdy) begin
            guess_q <= bus.guess;
            state_q <= EXACT;
          end
        end
        EXACT: begin
          wk_q    <= ex_wk_d;
          used_q  <= ex_used_d;
          idx_q   <= '0;
          state_q <= PARTIAL;
        end
        PARTIAL: begin
          wk_q   <= pt_wk_d;
          used_q <= pt_used_d;
          idx_q  <= idx_q + IW'(1);
          if (idx_q == IW'(PEGS - 1)) begin
            state_q <= DONE;
            fb_q    <= pt_wk_d;
            ex_q    <= ex_n_d;
            pa_q    <= pa_n_d;
            fbv_q   <= 1'b1;
            turn_q  <= turn_d;
            if (ex_n_d == CNT_W'(PEGS)) begin
              win_q  <= 1'b1;
              over_q <= 1'b1;
            end
            if (turn_d == TURN_W'(MAX_TURNS))
              over_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.guess_ready = rdy;
  assign bus.fb          = fb_q;
  assign bus.exact_cnt   = ex_q;
  assign bus.partial_cnt = pa_q;
  assign bus.fb_valid    = fbv_q;
  assign turn            = turn_q;
  assign win             = win_q;
  assign game_over       = over_q;
  assign last_turn       = (turn_q == TURN_W'(MAX_TURNS - 1))
                           && !over_q;
endmodule

// File: tb/tb_feedback_scorer.sv
// Scoreboard bench for feedback_scorer
// (PEGS=4, COLOR_W=3, MAX_TURNS=8).
module tb_feedback_scorer;
  localparam int P  = 4;
  localparam int C  = 3;
  localparam int MT = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          new_game = 1'b0;
  logic [P*C-1:0] code = '0;
  logic [TW-1:0] turn;
  logic          last_turn, win, game_over;

  feedback_scorer_if #(.PEGS(P), .COLOR_W(C)) bus ();

  feedback_scorer #(
    .PEGS(P), .COLOR_W(C), .MAX_TURNS(MT), .TURN_W(TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_game  (new_game),
    .code      (code),
    .bus       (bus.slave),
    .turn      (turn),
    .last_turn (last_turn),
    .win       (win),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] fb;
    logic [2:0] ex;
    logic [2:0] pa;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(int a, int b,
                                     int c, int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic [7:0] model(logic [11:0] cd,
                                       logic [11:0] g);
    logic [7:0] f;
    bit used [4];
    f = '0;
    for (int i = 0; i < 4; i++) begin
      used[i] = (cd[i*3 +: 3] == g[i*3 +: 3]);
      if (used[i]) f[2*i +: 2] = 2'd2;
    end
    for (int i = 0; i < 4; i++) begin
      if (f[2*i +: 2] != 2'd2) begin
        for (int j = 0; j < 4; j++) begin
          if (f[2*i +: 2] == 2'd0 && !used[j] &&
              cd[j*3 +: 3] == g[i*3 +: 3]) begin
            used[j] = 1'b1;
            f[2*i +: 2] = 2'd1;
          end
        end
      end
    end
    return f;
  endfunction

  function automatic logic [2:0] cnt(logic [7:0] f,
                                     logic [1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++)
      if (f[2*i +: 2] == v) n = n + 3'd1;
    return n;
  endfunction

  // Pop one expectation per fb_valid and compare.
  always @(negedge clk) begin
    if (bus.fb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_fb_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fb", 32'(bus.fb), 32'(e.fb));
        check("exact_cnt", 32'(bus.exact_cnt), 32'(e.ex));
        check("partial_cnt", 32'(bus.partial_cnt),
              32'(e.pa));
        check("latency", cyc - e.acc, P + 1);
      end
    end
  end

  task automatic start_game(input logic [11:0] c);
    new_game = 1'b1;
    code     = c;
    @(negedge clk);
    new_game = 1'b0;
    check("ng_turn", 32'(turn), 0);
    check("ng_ready", 32'(bus.guess_ready), 1);
  endtask

  task automatic play(input logic [11:0] g,
                      input logic [7:0] efb);
    int k;
    k = 0;
    while (bus.guess_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.guess_ready !== 1'b1) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bus.guess = g;
    bus.guess_valid = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{efb, cnt(efb, 2'd2),
                   cnt(efb, 2'd1), cyc});
    bus.guess_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("fbv_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    check("fb_hold", 32'(bus.fb), 32'(efb));
    check("fbv_pulse", 32'(bus.fb_valid), 0);
  endtask

  // Offer a guess that will be aborted: nothing pushed.
  task automatic offer_raw(input logic [11:0] g);
    bus.guess = g;
    bus.guess_valid = 1'b1;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] rc, rg;
    bus.guess = '0;
    bus.guess_valid = 1'b0;

    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_fb", 32'(bus.fb), 0);
    check("rst_exact", 32'(bus.exact_cnt), 0);
    check("rst_partial", 32'(bus.partial_cnt), 0);
    check("rst_fbv", 32'(bus.fb_valid), 0);
    check("rst_turn", 32'(turn), 0);
    check("rst_last", 32'(last_turn), 0);
    check("rst_win", 32'(win), 0);
    check("rst_over", 32'(game_over), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.guess_ready), 1);

    start_game(pk(0, 1, 2, 3));
    play(pk(0, 1, 2, 3), 8'hAA);
    check("win_exact", 32'(bus.exact_cnt), 4);
    check("win_partial", 32'(bus.partial_cnt), 0);
    check("win_win", 32'(win), 1);
    check("win_over", 32'(game_over), 1);
    check("win_turn", 32'(turn), 1);
    check("win_ready", 32'(bus.guess_ready), 0);

    start_game(pk(0, 1, 2, 3));
    play(pk(1, 0, 3, 2), 8'h55);
    check("perm_partial", 32'(bus.partial_cnt), 4);
    check("perm_win", 32'(win), 0);
    check("perm_turn", 32'(turn), 1);

    start_game(pk(1, 1, 2, 3));
    play(pk(1, 2, 1, 1), 8'h16);
    check("mult_exact", 32'(bus.exact_cnt), 1);
    check("mult_partial", 32'(bus.partial_cnt), 2);

    start_game(pk(0, 1, 2, 3));
    for (int t = 1; t <= MT; t++) begin
      play(pk(7, 7, 7, 7), 8'h00);
      check("lose_turn", 32'(turn), t);
      if (t == MT - 1)
        check("last_turn", 32'(last_turn), 1);
    end
    check("lose_over", 32'(game_over), 1);
    check("lose_win", 32'(win), 0);
    check("lose_last", 32'(last_turn), 0);
    check("lose_ready", 32'(bus.guess_ready), 0);
    bus.guess = pk(0, 1, 2, 3);
    bus.guess_valid = 1'b1;
    repeat (12) @(negedge clk);
    bus.guess_valid = 1'b0;
    check("ignored_turn", 32'(turn), MT);
    check("ignored_win", 32'(win), 0);

    for (int r = 0; r < 12; r++) begin
      rc = pk($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      rg = pk($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      start_game(rc);
      play(rg, model(rc, rg));
      check("rand_turn", 32'(turn), 1);
      check("rand_win", 32'(win),
            32'(cnt(model(rc, rg), 2'd2) == 3'd4));
    end

    start_game(pk(0, 1, 2, 3));
    play(pk(7, 7, 7, 7), 8'h00);
    offer_raw(pk(1, 0, 3, 2));
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("ng_abort_turn", 32'(turn), 0);
    check("ng_abort_ready", 32'(bus.guess_ready), 1);
    check("ng_abort_fb", 32'(bus.fb), 0);
    repeat (10) @(negedge clk);

    play(pk(1, 0, 3, 2), 8'h55);
    offer_raw(pk(0, 1, 2, 3));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_abort_turn", 32'(turn), 0);
    check("rst_abort_ready", 32'(bus.guess_ready), 1);
    check("rst_abort_fb", 32'(bus.fb), 0);
    check("rst_abort_exact", 32'(bus.exact_cnt), 0);
    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
